// File: rtl/mips_pkg.sv
// Shared opcodes, funct codes, ALU operation codes and FSM state
// encodings for the multicycle MIPS control unit.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] F_ADD = 6'b100000;
  localparam logic [5:0] F_SUB = 6'b100010;
  localparam logic [5:0] F_AND = 6'b100100;
  localparam logic [5:0] F_OR  = 6'b100101;
  localparam logic [5:0] F_SLT = 6'b101010;
  localparam logic [5:0] F_SLL = 6'b000000;
  localparam logic [5:0] F_SRL = 6'b000010;

  typedef enum logic [3:0] {
    ALU_AND = 4'b0000,
    ALU_OR  = 4'b0001,
    ALU_ADD = 4'b0010,
    ALU_SUB = 4'b0110,
    ALU_SLT = 4'b0111,
    ALU_SLL = 4'b1000,
    ALU_SRL = 4'b1001
  } alu_op_e;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_RTYPEEX = 4'd6,
    S_RTYPEWB = 4'd7,
    S_BEQEX   = 4'd8,
    S_IMMEX   = 4'd9,
    S_IMMWB   = 4'd10,
    S_JEX     = 4'd11
  } state_e;

  function automatic logic op_legal(logic [5:0] op);
    return op inside {OP_RTYPE, OP_LW, OP_SW, OP_BEQ,
                      OP_ADDI, OP_ORI, OP_J};
  endfunction

endpackage

// File: rtl/mips_aludec.sv
// R-type funct field to ALU operation decoder; unknown
// funct codes fall back to ADD.
module mips_aludec
  import mips_pkg::*;
(
  input  logic [5:0] funct,
  output logic [3:0] alucontrol
);

  always_comb begin
    alucontrol = ALU_ADD;
    unique case (funct)
      F_ADD:   alucontrol = ALU_ADD;
      F_SUB:   alucontrol = ALU_SUB;
      F_AND:   alucontrol = ALU_AND;
      F_OR:    alucontrol = ALU_OR;
      F_SLT:   alucontrol = ALU_SLT;
      F_SLL:   alucontrol = ALU_SLL;
      F_SRL:   alucontrol = ALU_SRL;
      default: alucontrol = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mips_controller.sv
// Multicycle MIPS control FSM: Moore decode of state, with the
// fetch-stage IR/PC loads qualified by the memory ready handshake.
module mips_controller
  import mips_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       memready,
  output logic       memread,
  output logic       memwrite,
  output logic       iord,
  output logic       irwrite,
  output logic       pcwrite,
  output logic       pcwriteCond,
  output logic [1:0] pcsource,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [3:0] alucontrol,
  output logic       memtoreg,
  output logic       regdst,
  output logic       regwrite,
  output logic       illegal,
  output logic [3:0] state
);

  state_e     state_q;
  state_e     state_d;
  logic [3:0] funct_alu;
  logic       ir_en;
  logic       pc_en;
  logic       pcc_en;
  logic       rw_en;
  logic       mw_en;
  logic       ill_en;

  mips_aludec u_aludec (
    .funct      (funct),
    .alucontrol (funct_alu)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_FETCH:   if (memready) state_d = S_DECODE;
      S_DECODE: begin
        unique case (op)
          OP_LW, OP_SW:    state_d = S_MEMADR;
          OP_RTYPE:        state_d = S_RTYPEEX;
          OP_BEQ:          state_d = S_BEQEX;
          OP_ADDI, OP_ORI: state_d = S_IMMEX;
          OP_J:            state_d = S_JEX;
          default:         state_d = S_FETCH;
        endcase
      end
      S_MEMADR:
        state_d = (op == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:   if (memready) state_d = S_MEMWB;
      S_MEMWB:   state_d = S_FETCH;
      S_MEMWR:   if (memready) state_d = S_FETCH;
      S_RTYPEEX: state_d = S_RTYPEWB;
      S_RTYPEWB: state_d = S_FETCH;
      S_BEQEX:   state_d = S_FETCH;
      S_IMMEX:   state_d = S_IMMWB;
      S_IMMWB:   state_d = S_FETCH;
      S_JEX:     state_d = S_FETCH;
      default:   state_d = S_FETCH;
    endcase
  end

  always_comb begin
    memread    = 1'b0;
    iord       = 1'b0;
    pcsource   = 2'b00;
    alusrca    = 1'b0;
    alusrcb    = 2'b00;
    alucontrol = ALU_ADD;
    memtoreg   = 1'b0;
    regdst     = 1'b0;
    ir_en      = 1'b0;
    pc_en      = 1'b0;
    pcc_en     = 1'b0;
    rw_en      = 1'b0;
    mw_en      = 1'b0;
    ill_en     = 1'b0;
    unique case (state_q)
      S_FETCH: begin
        memread = 1'b1;
        alusrcb = 2'b01;
        ir_en   = memready;
        pc_en   = memready;
      end
      S_DECODE: begin
        alusrcb = 2'b11;
        ill_en  = !op_legal(op);
      end
      S_MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      S_MEMRD: begin
        memread = 1'b1;
        iord    = 1'b1;
      end
      S_MEMWB: begin
        rw_en    = 1'b1;
        memtoreg = 1'b1;
      end
      S_MEMWR: begin
        mw_en = 1'b1;
        iord  = 1'b1;
      end
      S_RTYPEEX: begin
        alusrca    = 1'b1;
        alucontrol = funct_alu;
      end
      S_RTYPEWB: begin
        rw_en  = 1'b1;
        regdst = 1'b1;
      end
      S_BEQEX: begin
        alusrca    = 1'b1;
        alucontrol = ALU_SUB;
        pcc_en     = 1'b1;
        pcsource   = 2'b01;
      end
      S_IMMEX: begin
        alusrca    = 1'b1;
        alusrcb    = 2'b10;
        alucontrol = (op == OP_ORI) ? ALU_OR : ALU_ADD;
      end
      S_IMMWB:   rw_en = 1'b1;
      S_JEX: begin
        pc_en    = 1'b1;
        pcsource = 2'b10;
      end
      default: ;
    endcase
  end

  // Enables are gated by reset so nothing commits while held in reset.
  assign irwrite     = ir_en  & reset;
  assign pcwrite     = pc_en  & reset;
  assign pcwriteCond = pcc_en & reset;
  assign regwrite    = rw_en  & reset;
  assign memwrite    = mw_en  & reset;
  assign illegal     = ill_en & reset;
  assign state       = state_q;

endmodule

// File: tb/tb_mips_controller.sv
// Randomized self-checking bench for mips_controller against a
// per-instruction sequence model built from the state table.
module tb_mips_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] op;
  logic [5:0] funct;
  logic       memready;
  logic       memread;
  logic       memwrite;
  logic       iord;
  logic       irwrite;
  logic       pcwrite;
  logic       pcwriteCond;
  logic [1:0] pcsource;
  logic       alusrca;
  logic [1:0] alusrcb;
  logic [3:0] alucontrol;
  logic       memtoreg;
  logic       regdst;
  logic       regwrite;
  logic       illegal;
  logic [3:0] state;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    int st;
    bit mr;
  } step_t;

  localparam logic [5:0] R_OP  = 6'b000000;
  localparam logic [5:0] LW    = 6'b100011;
  localparam logic [5:0] SW    = 6'b101011;
  localparam logic [5:0] BEQ   = 6'b000100;
  localparam logic [5:0] ADDI  = 6'b001000;
  localparam logic [5:0] ORI   = 6'b001101;
  localparam logic [5:0] JMP   = 6'b000010;

  mips_controller dut (
    .clk         (clk),
    .reset       (reset),
    .op          (op),
    .funct       (funct),
    .memready    (memready),
    .memread     (memread),
    .memwrite    (memwrite),
    .iord        (iord),
    .irwrite     (irwrite),
    .pcwrite     (pcwrite),
    .pcwriteCond (pcwriteCond),
    .pcsource    (pcsource),
    .alusrca     (alusrca),
    .alusrcb     (alusrcb),
    .alucontrol  (alucontrol),
    .memtoreg    (memtoreg),
    .regdst      (regdst),
    .regwrite    (regwrite),
    .illegal     (illegal),
    .state       (state)
  );

  always #5 clk = ~clk;

  logic [22:0] obs;
  assign obs = {memread, memwrite, iord, irwrite, pcwrite,
                pcwriteCond, pcsource, alusrca, alusrcb,
                alucontrol, memtoreg, regdst, regwrite,
                illegal, state};

  function automatic logic [3:0] alu_ref(logic [5:0] f);
    case (f)
      6'b100010: return 4'b0110;
      6'b100100: return 4'b0000;
      6'b100101: return 4'b0001;
      6'b101010: return 4'b0111;
      6'b000000: return 4'b1000;
      6'b000010: return 4'b1001;
      default:   return 4'b0010;
    endcase
  endfunction

  // Expected output bundle for one cycle spent in state st.
  function automatic logic [22:0] model(int st, bit mr,
                                        logic [5:0] o,
                                        logic [5:0] f);
    logic mrd = 0, mwr = 0, iod = 0, irw = 0, pcw = 0;
    logic pcc = 0, asa = 0, mtr = 0, rd = 0, rw = 0;
    logic ill = 0;
    logic [1:0] ps = 0, asb = 0;
    logic [3:0] alu = 4'b0010;
    logic [3:0] s4 = 4'(st);
    case (st)
      0:  begin mrd = 1; asb = 1; irw = mr; pcw = mr; end
      1:  begin
        asb = 3;
        ill = !(o inside {R_OP, LW, SW, BEQ, ADDI, ORI, JMP});
      end
      2:  begin asa = 1; asb = 2; end
      3:  begin mrd = 1; iod = 1; end
      4:  begin rw = 1; mtr = 1; end
      5:  begin mwr = 1; iod = 1; end
      6:  begin asa = 1; alu = alu_ref(f); end
      7:  begin rw = 1; rd = 1; end
      8:  begin asa = 1; alu = 4'b0110; pcc = 1; ps = 1; end
      9:  begin
        asa = 1; asb = 2;
        alu = (o == ORI) ? 4'b0001 : 4'b0010;
      end
      10: rw = 1;
      11: begin pcw = 1; ps = 2; end
      default: ;
    endcase
    return {mrd, mwr, iod, irw, pcw, pcc, ps, asa, asb,
            alu, mtr, rd, rw, ill, s4};
  endfunction

  function automatic step_t mk(int st, bit mr);
    step_t s;
    s.st = st;
    s.mr = mr;
    return s;
  endfunction

  // Runs one instruction from FETCH with fw fetch waits and mw
  // data-memory waits, checking every cycle and the final return.
  task automatic run_instr(input logic [5:0] o, input logic [5:0] f,
                           input int fw, input int mw,
                           input string name);
    step_t q[$];
    logic [22:0] exp;
    for (int i = 0; i < fw; i++) q.push_back(mk(0, 0));
    q.push_back(mk(0, 1));
    q.push_back(mk(1, 1'($urandom)));
    case (o)
      LW: begin
        q.push_back(mk(2, 1'($urandom)));
        for (int i = 0; i < mw; i++) q.push_back(mk(3, 0));
        q.push_back(mk(3, 1));
        q.push_back(mk(4, 1'($urandom)));
      end
      SW: begin
        q.push_back(mk(2, 1'($urandom)));
        for (int i = 0; i < mw; i++) q.push_back(mk(5, 0));
        q.push_back(mk(5, 1));
      end
      R_OP: begin
        q.push_back(mk(6, 1'($urandom)));
        q.push_back(mk(7, 1'($urandom)));
      end
      BEQ: q.push_back(mk(8, 1'($urandom)));
      ADDI, ORI: begin
        q.push_back(mk(9, 1'($urandom)));
        q.push_back(mk(10, 1'($urandom)));
      end
      JMP: q.push_back(mk(11, 1'($urandom)));
      default: ;
    endcase
    foreach (q[i]) begin
      memready = q[i].mr;
      op    = (q[i].st == 0) ? 6'($urandom) : o;
      funct = (q[i].st == 0) ? 6'($urandom) : f;
      #4;
      exp = model(q[i].st, q[i].mr, op, funct);
      n_tests++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL %s cycle %0d: got %h want %h",
                 name, i, obs, exp);
      end
      @(posedge clk);
      #1;
    end
    n_tests++;
    if (state !== 4'd0) begin
      n_fail++;
      $display("FAIL %s end: state got %0d want 0", name, state);
    end
  endtask

  task automatic test_reset();
    logic [22:0] exp;
    reset = 1'b0;
    memready = 1'b1;
    op = 6'b100011;
    funct = 6'b0;
    repeat (2) @(posedge clk);
    #1;
    exp = model(0, 0, op, funct);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL reset_hold: got %h want %h", obs, exp);
    end
    reset = 1'b1;
    #1;
    n_tests++;
    if ({irwrite, pcwrite, state} !== {2'b11, 4'd0}) begin
      n_fail++;
      $display("FAIL reset_release: got %b%b st %0d want 11 st 0",
               irwrite, pcwrite, state);
    end
    run_instr(R_OP, 6'b100000, 0, 0, "post_reset_add");
  endtask

  task automatic test_rtype();
    run_instr(R_OP, 6'b100000, 0, 0, "rtype_add");
    run_instr(R_OP, 6'b100010, 1, 0, "rtype_sub");
    run_instr(R_OP, 6'b000010, 0, 0, "rtype_srl");
    run_instr(R_OP, 6'b111111, 0, 0, "rtype_unknown");
  endtask

  task automatic test_lw_wait();
    run_instr(LW, 6'($urandom), 0, 2, "lw_wait2");
    run_instr(SW, 6'($urandom), 2, 1, "sw_waits");
  endtask

  task automatic test_beq_j();
    run_instr(BEQ, 6'($urandom), 0, 0, "beq");
    run_instr(JMP, 6'($urandom), 0, 0, "jump");
    run_instr(ORI, 6'($urandom), 0, 0, "ori");
    run_instr(ADDI, 6'($urandom), 0, 0, "addi");
  endtask

  task automatic test_illegal();
    run_instr(6'b111111, 6'($urandom), 0, 0, "illegal_3f");
    run_instr(6'b000001, 6'($urandom), 1, 0, "illegal_01");
  endtask

  task automatic test_cpi();
    logic [5:0] ops [8] = '{R_OP, LW, SW, BEQ, ADDI, ORI, JMP,
                            6'b110000};
    int cpis [8] = '{4, 5, 4, 3, 4, 4, 3, 2};
    int cyc;
    foreach (ops[k]) begin
      memready = 1'b1;
      op = ops[k];
      funct = 6'b100000;
      cyc = 0;
      do begin
        @(posedge clk);
        #1;
        cyc++;
      end while (state !== 4'd0 && cyc < 20);
      n_tests++;
      if (cyc != cpis[k]) begin
        n_fail++;
        $display("FAIL cpi op %b: got %0d want %0d",
                 ops[k], cyc, cpis[k]);
      end
    end
  endtask

  task automatic test_reset_mid_sw();
    logic [22:0] exp;
    memready = 1'b1;
    op = SW;
    funct = 6'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    memready = 1'b0;
    #2;
    n_tests++;
    if ({memwrite, state} !== {1'b1, 4'd5}) begin
      n_fail++;
      $display("FAIL sw_pre_abort: memwrite %b st %0d want 1 st 5",
               memwrite, state);
    end
    reset = 1'b0;
    #1;
    exp = model(0, 0, op, funct);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL sw_abort: got %h want %h", obs, exp);
    end
    @(posedge clk);
    #1;
    reset = 1'b1;
    run_instr(LW, 6'b0, 1, 0, "lw_after_abort");
  endtask

  task automatic test_random();
    logic [5:0] ops [8] = '{R_OP, LW, SW, BEQ, ADDI, ORI, JMP,
                            6'b101111};
    logic [5:0] fns [8] = '{6'b100000, 6'b100010, 6'b100100,
                            6'b100101, 6'b101010, 6'b000000,
                            6'b000010, 6'b011001};
    for (int n = 0; n < 40; n++) begin
      run_instr(ops[$urandom_range(7)], fns[$urandom_range(7)],
                $urandom_range(2), $urandom_range(3), "random");
    end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_rtype();
    test_lw_wait();
    test_beq_j();
    test_illegal();
    test_cpi();
    test_reset_mid_sw();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mips_controller.md
# mips_controller

Multicycle control unit for the MIPS processor. Holds the instruction-sequencing state machine that drives every control input of `mips_datapath` from the decoded `op`/`funct` fields. Paces each instruction's memory accesses with a ready handshake to the off-processor memory. Sits beside `mips_datapath` inside the processor top level.

## Interface
Parameters: none.

Ports:
- `clk`  in  1  single system clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `op`  in  6  instruction bits [31:26] from the datapath.
- `funct`  in  6  instruction bits [5:0] from the datapath.
- `memready`  in  1  memory has completed the current read or write this cycle.
- `memread`  out  1  memory read request.
- `memwrite`  out  1  memory write request.
- `iord`  out  1  memory address source: 0 = PC, 1 = ALUOut.
- `irwrite`  out  1  instruction register load enable.
- `pcwrite`  out  1  unconditional PC load.
- `pcwriteCond`  out  1  PC load when ALU `zero` is set.
- `pcsource`  out  2  PC source: 00 = ALU result, 01 = ALUOut, 10 = jump target.
- `alusrca`  out  1  ALU A input: 0 = PC, 1 = A.
- `alusrcb`  out  2  ALU B input: 00 = B, 01 = constant 1, 10/11 = zero-extended immediate.
- `alucontrol`  out  4  ALU operation code.
- `memtoreg`  out  1  register write data: 0 = ALUOut, 1 = MDR.
- `regdst`  out  1  destination register: 0 = rt, 1 = rd.
- `regwrite`  out  1  register file write enable.
- `illegal`  out  1  one-cycle pulse in DECODE when `op` is unsupported.
- `state`  out  4  current state encoding, for debug and the bench.

## Operation
- Supported opcodes:
  - R-type 000000
  - lw 100011
  - sw 101011
  - beq 000100
  - addi 001000
  - ori 001101
  - j 000010
- Immediates are zero-extended, as the datapath implements them.
- R-type `funct` to `alucontrol` mapping:
  - add 100000 -> ADD 0010
  - sub 100010 -> SUB 0110
  - and 100100 -> AND 0000
  - or 100101 -> OR 0001
  - slt 101010 -> SLT 0111
  - sll 000000 -> SLL 1000
  - srl 000010 -> SRL 1001
  - any other `funct` -> ADD.
- Outputs not listed for a state are 0, except `alucontrol`, which defaults to ADD.

States, their asserted outputs, and transitions:
- FETCH: `memread`=1, `iord`=0, `alusrca`=0, `alusrcb`=01, ADD, `pcsource`=00. `irwrite` and `pcwrite` are asserted only while `memready`=1. Stays in FETCH until `memready`=1, then goes to DECODE.
- DECODE: `alusrca`=0, `alusrcb`=11, ADD; this precomputes the branch target PC+1+imm into ALUOut. Next state by opcode:
  - lw/sw -> MEMADR
  - R -> RTYPEEX
  - beq -> BEQEX
  - addi/ori -> IMMEX
  - j -> JEX
  - other -> FETCH, with `illegal`=1.
- MEMADR: `alusrca`=1, `alusrcb`=10, ADD. Next: lw -> MEMRD, sw -> MEMWR.
- MEMRD: `memread`=1, `iord`=1. Waits for `memready`, then goes to MEMWB.
- MEMWB: `regwrite`=1, `memtoreg`=1, `regdst`=0. Next: FETCH.
- MEMWR: `memwrite`=1, `iord`=1. Waits for `memready`, then goes to FETCH.
- RTYPEEX: `alusrca`=1, `alusrcb`=00, `alucontrol` from `funct`. Next: RTYPEWB.
- RTYPEWB: `regwrite`=1, `regdst`=1, `memtoreg`=0. Next: FETCH.
- BEQEX: `alusrca`=1, `alusrcb`=00, SUB, `pcwriteCond`=1, `pcsource`=01. Next: FETCH.
- IMMEX: `alusrca`=1, `alusrcb`=10; ADD for addi, OR for ori. Next: IMMWB.
- IMMWB: `regwrite`=1, `regdst`=0, `memtoreg`=0. Next: FETCH.
- JEX: `pcwrite`=1, `pcsource`=10. Next: FETCH.

## Timing
- Outputs are Moore decodes of `state`. The only exceptions are `irwrite` and `pcwrite` in FETCH, which are combinationally ANDed with `memready`.
- Cycles per instruction with zero-wait memory (`memready` tied high):
  - beq, j: 3
  - R-type, addi, ori, sw: 4
  - lw: 5
- Each wait cycle on a memory access adds one cycle to that access.
- Handshake: `memread`/`memwrite` and `iord` stay stable from the first request cycle through the cycle in which `memready`=1. `memready` in any non-memory state is ignored.
- While `reset`=0:
  - `state` is FETCH asynchronously.
  - All enables are forced to 0: `irwrite`, `pcwrite`, `pcwriteCond`, `regwrite`, `memwrite`, `illegal`.
  - Other outputs show the FETCH values, so `memread` is 1.
- A reset asserted mid-instruction abandons any pending access immediately; `memwrite` drops in the same cycle.
- On reset release, fetch begins on the first rising edge.

## Structure
- Package `mips_pkg` holds:
  - the opcode and funct localparams
  - an `alucontrol` enum (4-bit)
  - a state enum (4-bit) with explicit encodings: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, RTYPEEX=6, RTYPEWB=7, BEQEX=8, IMMEX=9, IMMWB=10, JEX=11.
- One sub-module, `mips_aludec`: combinational `funct` -> `alucontrol` decoder, used in RTYPEEX.

## Test plan
- Reset low, with `memready`=1 -> `state`=0, `memread`=1, all enables 0. Release reset -> next cycle `irwrite`=`pcwrite`=1.
- R-type add (`op`=0, `funct`=100000), `memready`=1 -> states 0,1,6,7,0. `alucontrol`=0010 in RTYPEEX; `regwrite`=`regdst`=1 in RTYPEWB.
- lw with `memready` held low 2 cycles in MEMRD -> MEMRD lasts 3 cycles, `iord`=1 throughout, then MEMWB with `memtoreg`=1, `regwrite`=1. Total 7 cycles.
- beq -> BEQEX with `alucontrol`=0110, `pcwriteCond`=1, `pcsource`=01. j -> JEX with `pcwrite`=1, `pcsource`=10. Both 3 cycles.
- `op`=111111 -> `illegal`=1 for one cycle in DECODE, return to FETCH, no `regwrite`/`memwrite` asserted.
- sw with reset pulled low during MEMWR while `memready`=0 -> `memwrite` falls immediately, `state`=0. After release, a clean fetch follows.
